// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
// add_pipe : elastic pipelined signed adder/subtractor with saturation and
//            a saturating overflow-event counter.          rev 1.0
// ============================================================================
module add_pipe #(
  parameter int ARG_WIDTH = 32,
  parameter int RES_WIDTH = ARG_WIDTH + 1,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arg_vld,
  output logic                 arg_rdy,
  input  logic [ARG_WIDTH-1:0] a,
  input  logic [ARG_WIDTH-1:0] b,
  input  logic                 sub,
  input  logic                 sat,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [RES_WIDTH-1:0] res,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  input  logic                 cnt_clr
);

  localparam logic [RES_WIDTH-1:0] MAX_POS =
    {{(RES_WIDTH-ARG_WIDTH+1){1'b0}}, {(ARG_WIDTH-1){1'b1}}};
  localparam logic [RES_WIDTH-1:0] MIN_NEG = ~MAX_POS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic signed [ARG_WIDTH:0] a_ext;
  logic signed [ARG_WIDTH:0] b_ext;
  logic signed [ARG_WIDTH:0] b_op;
  logic signed [ARG_WIDTH:0] sum;
  logic                      ovf_in;
  logic [RES_WIDTH-1:0]      res_in;

  // One guard bit makes the sum exact; overflow is judged against ARG_WIDTH.
  always_comb begin
    a_ext  = {a[ARG_WIDTH-1], a};
    b_ext  = {b[ARG_WIDTH-1], b};
    b_op   = sub ? (~b_ext + (ARG_WIDTH+1)'(1)) : b_ext;
    sum    = a_ext + b_op;
    ovf_in = sum[ARG_WIDTH] ^ sum[ARG_WIDTH-1];
    if (sat && ovf_in) begin
      res_in = sum[ARG_WIDTH] ? MIN_NEG : MAX_POS;
    end else begin
      res_in = RES_WIDTH'(sum);
    end
  end

  logic [STAGES-1:0]    vld_q;
  logic [STAGES-1:0]    ovf_q;
  logic [RES_WIDTH-1:0] data_q  [STAGES];
  logic [STAGES-1:0]    load;
  logic [STAGES-1:0]    in_vld;
  logic [STAGES-1:0]    in_ovf;
  logic [RES_WIDTH-1:0] in_data [STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Stage k can load unless it and every stage downstream are full and
      // the consumer is stalling; written flat to avoid a ripple chain.
      localparam logic [STAGES-1:0] BELOW = STAGES'((1 << k) - 1);
      assign load[k] = res_rdy || !(&(vld_q | BELOW));

      if (k == 0) begin : g_first
        assign in_vld[k]  = arg_vld;
        assign in_ovf[k]  = ovf_in;
        assign in_data[k] = res_in;
      end else begin : g_next
        assign in_vld[k]  = vld_q[k-1];
        assign in_ovf[k]  = ovf_q[k-1];
        assign in_data[k] = data_q[k-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          vld_q[i] <= in_vld[i];
          if (in_vld[i]) begin
            data_q[i] <= in_data[i];
            ovf_q[i]  <= in_ovf[i];
          end
        end
      end
    end
  end

  assign arg_rdy = load[0];
  assign res_vld = vld_q[STAGES-1];
  assign res     = data_q[STAGES-1];
  assign ovf     = ovf_q[STAGES-1];

  // Clear wins over a same-cycle overflow delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (res_vld && res_rdy && ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
// tb_add_pipe : directed self-checking bench for add_pipe (8-bit, 2 stages).
//               rev 1.0
// ============================================================================
module tb_add_pipe;

  logic       clk;
  logic       rst_n;
  logic       arg_vld;
  logic       arg_rdy;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       sat;
  logic       res_vld;
  logic       res_rdy;
  logic [8:0] res;
  logic       ovf;
  logic [1:0] ovf_cnt;
  logic       cnt_clr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] vec_a   [10];
  logic [7:0] vec_b   [10];
  logic       vec_sub [10];
  logic [8:0] vec_exp [10];

  add_pipe #(
    .ARG_WIDTH(8),
    .RES_WIDTH(9),
    .STAGES   (2),
    .CNT_WIDTH(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arg_vld(arg_vld),
    .arg_rdy(arg_rdy),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .sat    (sat),
    .res_vld(res_vld),
    .res_rdy(res_rdy),
    .res    (res),
    .ovf    (ovf),
    .ovf_cnt(ovf_cnt),
    .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operand pair into an idle pipeline; returns 1ns after the accept edge.
  task automatic push(input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input logic tv);
    @(negedge clk);
    a = av; b = bv; sub = sv; sat = tv; arg_vld = 1'b1;
    @(posedge clk);
    #1 arg_vld = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL reset_res_vld: got %b want 0", res_vld); end
    n_vec++; if (res !== 9'h000) begin n_err++; $display("FAIL reset_res: got %h want 000", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL reset_ovf_cnt: got %0d want 0", ovf_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (arg_rdy !== 1'b1) begin n_err++; $display("FAIL reset_arg_rdy: got %b want 1", arg_rdy); end
  endtask

  task automatic test_wrap();
    push(8'h64, 8'h32, 1'b0, 1'b0);       // 100 + 50
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL wrap_early_vld: got %b want 0", res_vld); end
    @(posedge clk); #1;
    n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL wrap_latency_vld: got %b want 1", res_vld); end
    n_vec++; if (res !== 9'h096) begin n_err++; $display("FAIL wrap_add_res: got %h want 096", res); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL wrap_add_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd1) begin n_err++; $display("FAIL wrap_add_cnt: got %0d want 1", ovf_cnt); end
    push(8'h9C, 8'h32, 1'b1, 1'b0);       // -100 - 50
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h16A) begin n_err++; $display("FAIL wrap_sub_res: got %h want 16a", res); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL wrap_sub_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd2) begin n_err++; $display("FAIL wrap_sub_cnt: got %0d want 2", ovf_cnt); end
  endtask

  task automatic test_no_ovf();
    push(8'hFB, 8'h03, 1'b0, 1'b1);       // -5 + 3, saturate on
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h1FE) begin n_err++; $display("FAIL noovf_neg_res: got %h want 1fe", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL noovf_neg_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd2) begin n_err++; $display("FAIL noovf_neg_cnt: got %0d want 2", ovf_cnt); end
    push(8'h7F, 8'h80, 1'b0, 1'b0);       // 127 + -128
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h1FF) begin n_err++; $display("FAIL noovf_edge_res: got %h want 1ff", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL noovf_edge_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    push(8'h64, 8'h32, 1'b0, 1'b1);       // 100 + 50 -> 127
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h07F) begin n_err++; $display("FAIL sat_pos_res: got %h want 07f", res); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_pos_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd3) begin n_err++; $display("FAIL sat_pos_cnt: got %0d want 3", ovf_cnt); end
    push(8'h9C, 8'h32, 1'b1, 1'b1);       // -100 - 50 -> -128
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h180) begin n_err++; $display("FAIL sat_neg_res: got %h want 180", res); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_neg_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt_hold: got %0d want 3", ovf_cnt); end
    push(8'h00, 8'h80, 1'b1, 1'b1);       // 0 - (-128) -> 127
    @(posedge clk); #1;
    n_vec++; if (res !== 9'h07F) begin n_err++; $display("FAIL sat_minneg_res: got %h want 07f", res); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_minneg_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clear: got %0d want 0", ovf_cnt); end
    @(negedge clk);
    a = 8'h64; b = 8'h32; sub = 1'b0; sat = 1'b0; arg_vld = 1'b1;
    repeat (5) @(posedge clk);
    #1 arg_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (ovf_cnt !== 2'd3) begin n_err++; $display("FAIL cnt_saturate: got %0d want 3", ovf_cnt); end
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL cnt_drain_vld: got %b want 0", res_vld); end
    push(8'h64, 8'h32, 1'b0, 1'b0);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr_priority: got %0d want 0", ovf_cnt); end
    @(posedge clk); #1;
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr_after: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    res_rdy = 1'b1;
    sat = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
      @(negedge clk);
      arg_vld = (sent < 10);
      if (sent < 10) begin a = vec_a[sent]; b = vec_b[sent]; sub = vec_sub[sent]; end
      #1;
      n_vec++; if (arg_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_arg_rdy cyc %0d: got %b want 1", cyc, arg_rdy); end
      if (res_vld && res_rdy) begin
        n_vec++; if (res !== vec_exp[recv]) begin n_err++; $display("FAIL b2b_res[%0d]: got %h want %h", recv, res, vec_exp[recv]); end
        if (recv == 9) begin
          n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL b2b_throughput: last result cycle %0d want 11", cyc); end
        end
        recv++;
      end
      if (arg_vld && arg_rdy) sent++;
    end
    arg_vld = 1'b0;
    n_vec++; if (recv !== 10) begin n_err++; $display("FAIL b2b_count: got %0d want 10", recv); end
    @(posedge clk); #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup: got %b want 0", res_vld); end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         recv = 0;
    logic       stalled = 1'b0;
    logic       exp_rdy;
    logic [8:0] held = '0;
    sat = 1'b0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        n_vec++; if (res_vld !== 1'b1 || res !== held) begin n_err++; $display("FAIL bp_hold cyc %0d: got vld %b res %h want vld 1 res %h", cyc, res_vld, res, held); end
      end
      res_rdy = 1'($urandom_range(0, 1));
      arg_vld = (sent < 10);
      if (sent < 10) begin a = vec_a[sent]; b = vec_b[sent]; sub = vec_sub[sent]; end
      #1;
      exp_rdy = !(((sent - recv) == 2) && !res_rdy);
      n_vec++; if (arg_rdy !== exp_rdy) begin n_err++; $display("FAIL bp_arg_rdy cyc %0d: got %b want %b", cyc, arg_rdy, exp_rdy); end
      stalled = res_vld && !res_rdy;
      held = res;
      if (res_vld && res_rdy) begin
        n_vec++; if (res !== vec_exp[recv]) begin n_err++; $display("FAIL bp_res[%0d]: got %h want %h", recv, res, vec_exp[recv]); end
        recv++;
      end
      if (arg_vld && arg_rdy) sent++;
    end
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    n_vec++; if (recv !== 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", recv); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", res_vld); end
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL bp_cnt: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_reset_inflight();
    int got = 0;
    push(8'h64, 8'h32, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ovf_cnt !== 2'd1) begin n_err++; $display("FAIL rst_pre_cnt: got %0d want 1", ovf_cnt); end
    @(negedge clk);
    res_rdy = 1'b0;
    a = 8'h64; b = 8'h32; sub = 1'b0; sat = 1'b0; arg_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1 arg_vld = 1'b0;
    n_vec++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL rst_full_vld: got %b want 1", res_vld); end
    n_vec++; if (arg_rdy !== 1'b0) begin n_err++; $display("FAIL rst_full_arg_rdy: got %b want 0", arg_rdy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL rst_async_vld: got %b want 0", res_vld); end
    n_vec++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL rst_async_cnt: got %0d want 0", ovf_cnt); end
    n_vec++; if (res !== 9'h000) begin n_err++; $display("FAIL rst_async_res: got %h want 000", res); end
    @(negedge clk);
    rst_n = 1'b1;
    res_rdy = 1'b1;
    push(8'h05, 8'h06, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (res_vld && res_rdy) begin
        got++;
        n_vec++; if (res !== 9'h00B) begin n_err++; $display("FAIL rst_after_res: got %h want 00b", res); end
      end
      @(posedge clk); #1;
    end
    n_vec++; if (got !== 1) begin n_err++; $display("FAIL rst_after_count: got %0d want 1", got); end
  endtask

  initial begin
    vec_a   = '{8'd0, 8'd12, 8'd24, 8'd36, 8'd48, 8'd60, 8'd72, 8'd84, 8'd96, 8'd108};
    vec_b   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    vec_sub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec_exp = '{9'd1, 9'd10, 9'd27, 9'd32, 9'd53, 9'd54, 9'd79, 9'd76, 9'd105, 9'd98};

    rst_n   = 1'b0;
    arg_vld = 1'b0;
    a       = '0;
    b       = '0;
    sub     = 1'b0;
    sat     = 1'b0;
    res_rdy = 1'b1;
    cnt_clr = 1'b0;

    test_reset();
    test_wrap();
    test_no_ovf();
    test_saturate();
    test_counter();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
